tdm_demux4: RTL and testbench



---
 rtl/tdm_pkg.sv | 12 +
 rtl/tdm_slot_ctr.sv | 41 ++++
 rtl/tdm_demux4.sv | 117 +++++++++++
 tb/tb_tdm_demux4.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared constants and types for the 4:1 TDM receive path.
package tdm_pkg;

    localparam int unsigned NUM_SLOTS = 4;
    localparam int unsigned SLOT_W    = 2;

    typedef enum logic [0:0] {
        StHunt,
        StLocked
    } state_e;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Modulo-4 slot position counter with sync load-to-1, clear and wrap flag.
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              inc_in,
    input  logic              load_one_in,
    input  logic              clear_in,
    output logic [SLOT_W-1:0] slot_out,
    output logic              wrap_out
);

    logic [SLOT_W-1:0] slot_q;
    logic [SLOT_W-1:0] slot_d;

    // Next slot: clear beats load, load beats increment.
    always_comb begin
        slot_d = slot_q;
        if (clear_in) begin
            slot_d = '0;
        end else if (load_one_in) begin
            slot_d = SLOT_W'(1);
        end else if (inc_in) begin
            slot_d = slot_q + SLOT_W'(1);
        end
    end

    // Slot position register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_out = slot_q;
    assign wrap_out = inc_in && (slot_q == SLOT_W'(NUM_SLOTS - 1));

endmodule

// File: rtl/tdm_demux4.sv
// Receive side of the 4:1 TDM link: locks on slot-0 sync and fans samples out.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 valid_in,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 sync_in,
    output logic [WIDTH-1:0]     ch0_out,
    output logic [WIDTH-1:0]     ch1_out,
    output logic [WIDTH-1:0]     ch2_out,
    output logic [WIDTH-1:0]     ch3_out,
    output logic [NUM_SLOTS-1:0] ch_valid_out,
    output logic [SLOT_W-1:0]    slot_out,
    output logic                 locked_out,
    output logic                 frame_done_out,
    output logic                 sync_err_out
);

    state_e                state_q, state_d;
    logic [SLOT_W-1:0]     slot;
    logic                  wrap;
    logic                  ctr_inc, ctr_load_one, ctr_clear;
    logic [NUM_SLOTS-1:0]  wr_en;
    logic                  frame_done_d, sync_err_d;
    logic [WIDTH-1:0]      ch_q [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]  ch_valid_q;
    logic                  locked_q, frame_done_q, sync_err_q;

    tdm_slot_ctr u_slot_ctr (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .inc_in      (ctr_inc),
        .load_one_in (ctr_load_one),
        .clear_in    (ctr_clear),
        .slot_out    (slot),
        .wrap_out    (wrap)
    );

    // Lock FSM: decides which channel (if any) takes the sample and how the slot moves.
    always_comb begin
        state_d      = state_q;
        wr_en        = '0;
        ctr_inc      = 1'b0;
        ctr_load_one = 1'b0;
        ctr_clear    = 1'b0;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;
        if (valid_in) begin
            unique case (state_q)
                StHunt: begin
                    if (sync_in) begin
                        wr_en        = NUM_SLOTS'(1);
                        ctr_load_one = 1'b1;
                        state_d      = StLocked;
                    end
                end
                StLocked: begin
                    if (sync_in) begin
                        // Sync mid-frame restarts the frame at slot 0; partial frame is abandoned.
                        sync_err_d   = (slot != '0);
                        wr_en        = NUM_SLOTS'(1);
                        ctr_load_one = 1'b1;
                    end else if (slot == '0) begin
                        sync_err_d = 1'b1;
                        ctr_clear  = 1'b1;
                        state_d    = StHunt;
                    end else begin
                        wr_en        = NUM_SLOTS'(1) << slot;
                        ctr_inc      = 1'b1;
                        frame_done_d = wrap;
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    // State, channel bank and pulse registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= StHunt;
            locked_q     <= 1'b0;
            ch_valid_q   <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                ch_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            locked_q     <= (state_d == StLocked);
            ch_valid_q   <= wr_en;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (wr_en[i]) begin
                    ch_q[i] <= data_in;
                end
            end
        end
    end

    assign ch0_out        = ch_q[0];
    assign ch1_out        = ch_q[1];
    assign ch2_out        = ch_q[2];
    assign ch3_out        = ch_q[3];
    assign ch_valid_out   = ch_valid_q;
    assign slot_out       = slot;
    assign locked_out     = locked_q;
    assign frame_done_out = frame_done_q;
    assign sync_err_out   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4 with a frame-level reference model.
module tb_tdm_demux4;

    localparam int W = 8;

    logic         clk_in = 1'b0;
    logic         rst_in;
    logic         valid_in;
    logic [W-1:0] data_in;
    logic         sync_in;
    logic [W-1:0] ch0_out, ch1_out, ch2_out, ch3_out;
    logic [3:0]   ch_valid_out;
    logic [1:0]   slot_out;
    logic         locked_out, frame_done_out, sync_err_out;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int         m_locked;
    int         m_slot;
    logic [7:0] m_ch [4];
    int         m_vmask;
    int         m_fdone;
    int         m_err;

    tdm_demux4 #(.WIDTH(W)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .valid_in       (valid_in),
        .data_in        (data_in),
        .sync_in        (sync_in),
        .ch0_out        (ch0_out),
        .ch1_out        (ch1_out),
        .ch2_out        (ch2_out),
        .ch3_out        (ch3_out),
        .ch_valid_out   (ch_valid_out),
        .slot_out       (slot_out),
        .locked_out     (locked_out),
        .frame_done_out (frame_done_out),
        .sync_err_out   (sync_err_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input int act, input int exp);
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 0;
        m_slot   = 0;
        m_vmask  = 0;
        m_fdone  = 0;
        m_err    = 0;
        for (int i = 0; i < 4; i++) m_ch[i] = 8'h00;
    endtask

    // Frame rules: sync marks slot 0, slots advance 0..3, misplaced sync is an error.
    task automatic model_step(input bit v, input bit s, input logic [7:0] d);
        m_vmask = 0;
        m_fdone = 0;
        m_err   = 0;
        if (!v) return;
        if (m_locked == 0) begin
            if (s) begin
                m_ch[0] = d; m_vmask = 1; m_slot = 1; m_locked = 1;
            end
        end else if (s) begin
            m_err = (m_slot != 0);
            m_ch[0] = d; m_vmask = 1; m_slot = 1;
        end else if (m_slot == 0) begin
            m_err = 1; m_locked = 0;
        end else begin
            m_ch[m_slot] = d;
            m_vmask = 1 << m_slot;
            m_fdone = (m_slot == 3);
            m_slot  = (m_slot + 1) % 4;
        end
    endtask

    task automatic compare_all();
        vectors++;
        chk("ch0", ch0_out, m_ch[0]);
        chk("ch1", ch1_out, m_ch[1]);
        chk("ch2", ch2_out, m_ch[2]);
        chk("ch3", ch3_out, m_ch[3]);
        chk("ch_valid", ch_valid_out, m_vmask);
        chk("slot", slot_out, m_slot);
        chk("locked", locked_out, m_locked);
        chk("frame_done", frame_done_out, m_fdone);
        chk("sync_err", sync_err_out, m_err);
    endtask

    // Drive one cycle, advance the model, sample 1 time unit after the edge.
    task automatic step(input bit v, input bit s, input logic [7:0] d);
        valid_in = v;
        sync_in  = s;
        data_in  = d;
        model_step(v, s, d);
        @(posedge clk_in);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 8'hEE);
    endtask

    initial begin
        rst_in   = 1'b1;
        valid_in = 1'b0;
        sync_in  = 1'b0;
        data_in  = '0;
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;
        compare_all();
        chk("reset_locked_lit", locked_out, 0);
        chk("reset_slot_lit", slot_out, 0);
        rst_in = 1'b0;

        // Basic frame
        step(1, 1, 8'h11);
        chk("bf_v0_lit", ch_valid_out, 4'b0001);
        step(1, 0, 8'h22);
        chk("bf_v1_lit", ch_valid_out, 4'b0010);
        step(1, 0, 8'h33);
        chk("bf_v2_lit", ch_valid_out, 4'b0100);
        step(1, 0, 8'h44);
        chk("bf_v3_lit", ch_valid_out, 4'b1000);
        chk("bf_fdone_lit", frame_done_out, 1);
        chk("bf_ch3_lit", ch3_out, 8'h44);
        chk("bf_locked_lit", locked_out, 1);
        chk("bf_slot_wrap_lit", slot_out, 0);
        idle(1);
        chk("bf_fdone_clear_lit", frame_done_out, 0);

        // Missing sync drops lock, then relock
        step(1, 0, 8'h55);
        chk("ms_err_lit", sync_err_out, 1);
        chk("ms_locked_lit", locked_out, 0);
        chk("ms_ch0_kept_lit", ch0_out, 8'h11);
        step(1, 1, 8'h66);
        chk("ms_relock_lit", ch0_out, 8'h66);

        // Back to hunt via a second missing sync after a full frame
        step(1, 0, 8'h01); step(1, 0, 8'h02); step(1, 0, 8'h03);
        step(1, 0, 8'h99);
        // Hunt discard
        step(1, 0, 8'hAA);
        chk("hd_nov_lit", ch_valid_out, 0);
        step(1, 0, 8'hBB);
        step(1, 1, 8'h11);
        chk("hd_ch0_lit", ch0_out, 8'h11);
        chk("hd_slot_lit", slot_out, 1);
        step(1, 0, 8'h12); step(1, 0, 8'h13); step(1, 0, 8'h14);

        // Gapped frame
        step(1, 1, 8'h01); idle(2);
        chk("gap_slot_hold_lit", slot_out, 1);
        step(1, 0, 8'h02); idle(2);
        step(1, 0, 8'h03); idle(2);
        step(1, 0, 8'h04);
        chk("gap_fdone_lit", frame_done_out, 1);
        chk("gap_ch2_lit", ch2_out, 8'h03);
        idle(2);

        // Early sync
        step(1, 1, 8'h10);
        step(1, 0, 8'h20);
        step(1, 1, 8'h30);
        chk("es_err_lit", sync_err_out, 1);
        chk("es_ch0_lit", ch0_out, 8'h30);
        chk("es_ch2_lit", ch2_out, 8'h03);
        chk("es_slot_lit", slot_out, 1);
        chk("es_fdone_lit", frame_done_out, 0);

        // Async reset mid-frame
        step(1, 0, 8'h40);
        #2;
        rst_in = 1'b1;
        #1;
        model_reset();
        compare_all();
        chk("ar_ch1_lit", ch1_out, 0);
        chk("ar_valid_lit", ch_valid_out, 0);
        #1;
        rst_in = 1'b0;
        step(1, 0, 8'h77);
        chk("ar_ignore_lit", ch0_out, 0);
        chk("ar_hunt_lit", locked_out, 0);
        step(1, 1, 8'h78);
        step(1, 0, 8'h79);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
